// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-SRAM request FSM, load alignment, HI/LO, MEM->WB registers.
// Optional build macro MEM_STALL_CNT_EN adds the mem_stall_cnt output.
module mem_stage #(
    parameter logic [31:0] HI_RESET = 32'd0,
    parameter logic [31:0] LO_RESET = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_to_mem_valid,
    output logic        mem_allowin,
    input  logic        MemEn_EX_MEM,
    input  logic        MemToReg_EX_MEM,
    input  logic        mfc0_EX_MEM,
    input  logic [3:0]  MemWrite_EX_MEM,
    input  logic [3:0]  RegWrite_EX_MEM,
    input  logic        LB_EX_MEM,
    input  logic        LBU_EX_MEM,
    input  logic        LH_EX_MEM,
    input  logic        LHU_EX_MEM,
    input  logic [1:0]  LW_EX_MEM,
    input  logic [1:0]  MULT_EX_MEM,
    input  logic [1:0]  MFHL_EX_MEM,
    input  logic [1:0]  MTHL_EX_MEM,
    input  logic [4:0]  RegWaddr_EX_MEM,
    input  logic [31:0] ALUResult_EX_MEM,
    input  logic [31:0] MemWdata_EX_MEM,
    input  logic [31:0] PC_EX_MEM,
    input  logic [31:0] RegRdata1_EX_MEM,
    input  logic [31:0] RegRdata2_EX_MEM,
    input  logic [31:0] cp0Rdata_EX_MEM,
    input  logic [2:0]  s_size_EX_MEM,
    input  logic [31:0] muldiv_hi,
    input  logic [31:0] muldiv_lo,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [3:0]  RegWrite_MEM_WB,
    output logic [4:0]  RegWaddr_MEM_WB,
    output logic [31:0] RegWdata_MEM_WB,
    output logic [31:0] PC_MEM_WB,
    output logic [31:0] Bypass_MEM,
`ifdef MEM_STALL_CNT_EN
    output logic [31:0] mem_stall_cnt,
`endif
    output logic        mem_fwd_valid
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic        mem_valid, mem_ready_go, capture, commit;
    logic        mem_en_r, mem_to_reg_r, mfc0_r, lb_r, lbu_r, lh_r, lhu_r;
    logic [3:0]  mem_write_r, reg_write_r;
    logic [1:0]  lw_r, mult_r, mfhl_r, mthl_r, s_size_r;
    logic [4:0]  reg_waddr_r;
    logic [31:0] alu_result_r, mem_wdata_r, pc_r, rdata1_r, rdata2_r, cp0_rdata_r;
    logic [31:0] muldiv_hi_r, muldiv_lo_r, rdata_r, hi_r, lo_r;
    logic [31:0] load_data, reg_wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [1:0]  k;
    logic        unused_bits;

    assign unused_bits     = s_size_EX_MEM[2];
    assign mem_ready_go    = !mem_en_r || (state == DONE);
    assign mem_allowin     = !mem_valid || (mem_ready_go && wb_allowin);
    assign mem_to_wb_valid = mem_valid && mem_ready_go;
    assign capture         = exe_to_mem_valid && mem_allowin;
    assign commit          = mem_to_wb_valid && wb_allowin;

    // Request fields come straight from captured registers, so they cannot move while data_req is up.
    assign data_req   = (state == REQ);
    assign data_wr    = |mem_write_r;
    assign data_addr  = alu_result_r;
    assign data_wstrb = mem_write_r;
    assign data_wdata = mem_wdata_r;

    always_comb begin
        data_size = 2'd2;
        if (|mem_write_r)           data_size = s_size_r;
        else if (lb_r || lbu_r)     data_size = 2'd0;
        else if (lh_r || lhu_r)     data_size = 2'd1;
    end

    assign k        = alu_result_r[1:0];
    assign byte_sel = rdata_r[{k, 3'b000} +: 8];
    assign half_sel = k[1] ? rdata_r[31:16] : rdata_r[15:0];

    always_comb begin
        load_data = rdata_r;
        if (lb_r)            load_data = {{24{byte_sel[7]}}, byte_sel};
        else if (lbu_r)      load_data = {24'd0, byte_sel};
        else if (lh_r)       load_data = {{16{half_sel[15]}}, half_sel};
        else if (lhu_r)      load_data = {16'd0, half_sel};
        else if (lw_r == 2'b01) begin
            case (k)
                2'd0:    load_data = {rdata_r[7:0],  rdata2_r[23:0]};
                2'd1:    load_data = {rdata_r[15:0], rdata2_r[15:0]};
                2'd2:    load_data = {rdata_r[23:0], rdata2_r[7:0]};
                default: load_data = rdata_r;
            endcase
        end else if (lw_r == 2'b10) begin
            case (k)
                2'd0:    load_data = rdata_r;
                2'd1:    load_data = {rdata2_r[31:24], rdata_r[31:8]};
                2'd2:    load_data = {rdata2_r[31:16], rdata_r[31:16]};
                default: load_data = {rdata2_r[31:8],  rdata_r[31:24]};
            endcase
        end
    end

    // HI/LO update at the commit edge, so a younger MFHI/MFLO entering MEM on that edge reads the new value.
    always_comb begin
        reg_wdata = alu_result_r;
        if (mem_to_reg_r)   reg_wdata = load_data;
        else if (mfc0_r)    reg_wdata = cp0_rdata_r;
        else if (mfhl_r[1]) reg_wdata = hi_r;
        else if (mfhl_r[0]) reg_wdata = lo_r;
    end

    assign Bypass_MEM    = mem_valid ? reg_wdata : 32'd0;
    assign mem_fwd_valid = mem_valid && (|reg_write_r) && mem_ready_go;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid    <= 1'b0;
            state        <= IDLE;
            hi_r         <= HI_RESET;
            lo_r         <= LO_RESET;
            mem_en_r     <= 1'b0; mem_to_reg_r <= 1'b0; mfc0_r <= 1'b0;
            lb_r         <= 1'b0; lbu_r <= 1'b0; lh_r <= 1'b0; lhu_r <= 1'b0;
            mem_write_r  <= 4'd0; reg_write_r <= 4'd0;
            lw_r         <= 2'd0; mult_r <= 2'd0; mfhl_r <= 2'd0; mthl_r <= 2'd0; s_size_r <= 2'd0;
            reg_waddr_r  <= 5'd0;
            alu_result_r <= 32'd0; mem_wdata_r <= 32'd0; pc_r <= 32'd0;
            rdata1_r     <= 32'd0; rdata2_r <= 32'd0; cp0_rdata_r <= 32'd0;
            muldiv_hi_r  <= 32'd0; muldiv_lo_r <= 32'd0; rdata_r <= 32'd0;
            RegWrite_MEM_WB <= 4'd0; RegWaddr_MEM_WB <= 5'd0;
            RegWdata_MEM_WB <= 32'd0; PC_MEM_WB <= 32'd0;
        end else begin
            if (capture) begin
                mem_valid    <= 1'b1;
                mem_en_r     <= MemEn_EX_MEM;    mem_to_reg_r <= MemToReg_EX_MEM; mfc0_r <= mfc0_EX_MEM;
                lb_r         <= LB_EX_MEM;       lbu_r <= LBU_EX_MEM;
                lh_r         <= LH_EX_MEM;       lhu_r <= LHU_EX_MEM;
                mem_write_r  <= MemWrite_EX_MEM; reg_write_r <= RegWrite_EX_MEM;
                lw_r         <= LW_EX_MEM;       mult_r <= MULT_EX_MEM;
                mfhl_r       <= MFHL_EX_MEM;     mthl_r <= MTHL_EX_MEM;
                s_size_r     <= s_size_EX_MEM[1:0];
                reg_waddr_r  <= RegWaddr_EX_MEM;
                alu_result_r <= ALUResult_EX_MEM; mem_wdata_r <= MemWdata_EX_MEM; pc_r <= PC_EX_MEM;
                rdata1_r     <= RegRdata1_EX_MEM; rdata2_r <= RegRdata2_EX_MEM;
                cp0_rdata_r  <= cp0Rdata_EX_MEM;
                muldiv_hi_r  <= muldiv_hi;        muldiv_lo_r <= muldiv_lo;
            end else if (mem_allowin) begin
                mem_valid <= 1'b0;
            end

            case (state)
                IDLE: if (capture && MemEn_EX_MEM) state <= REQ;
                REQ:  if (data_addr_ok) state <= WAIT;
                WAIT: if (data_data_ok) begin
                    rdata_r <= data_rdata;
                    state   <= DONE;
                end
                default: if (wb_allowin) state <= (capture && MemEn_EX_MEM) ? REQ : IDLE;
            endcase

            if (commit) begin
                if (mult_r[1])      hi_r <= muldiv_hi_r;
                else if (mthl_r[1]) hi_r <= rdata1_r;
                if (mult_r[0])      lo_r <= muldiv_lo_r;
                else if (mthl_r[0]) lo_r <= rdata1_r;
                RegWrite_MEM_WB <= reg_write_r;
                RegWaddr_MEM_WB <= reg_waddr_r;
                RegWdata_MEM_WB <= reg_wdata;
                PC_MEM_WB       <= pc_r;
            end else if (wb_allowin) begin
                RegWrite_MEM_WB <= 4'd0;
            end
        end
    end

`ifdef MEM_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             mem_stall_cnt <= 32'd0;
        else if (mem_valid && !mem_ready_go) mem_stall_cnt <= mem_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage.
module tb_mem_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        exe_to_mem_valid, mem_allowin;
    logic        MemEn_EX_MEM, MemToReg_EX_MEM, mfc0_EX_MEM;
    logic [3:0]  MemWrite_EX_MEM, RegWrite_EX_MEM;
    logic        LB_EX_MEM, LBU_EX_MEM, LH_EX_MEM, LHU_EX_MEM;
    logic [1:0]  LW_EX_MEM, MULT_EX_MEM, MFHL_EX_MEM, MTHL_EX_MEM;
    logic [4:0]  RegWaddr_EX_MEM;
    logic [31:0] ALUResult_EX_MEM, MemWdata_EX_MEM, PC_EX_MEM, RegRdata1_EX_MEM, RegRdata2_EX_MEM, cp0Rdata_EX_MEM;
    logic [2:0]  s_size_EX_MEM;
    logic [31:0] muldiv_hi, muldiv_lo;
    logic        data_req, data_wr, data_addr_ok, data_data_ok, wb_allowin, mem_to_wb_valid, mem_fwd_valid;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb, RegWrite_MEM_WB;
    logic [4:0]  RegWaddr_MEM_WB;
    logic [31:0] RegWdata_MEM_WB, PC_MEM_WB, Bypass_MEM;
`ifdef MEM_STALL_CNT_EN
    logic [31:0] mem_stall_cnt;
`endif
    int total = 0, bad = 0, hs_cnt = 0, commit_cnt = 0, hs0, cm0;

    mem_stage dut (
        .clk(clk), .rst(rst), .exe_to_mem_valid(exe_to_mem_valid), .mem_allowin(mem_allowin),
        .MemEn_EX_MEM(MemEn_EX_MEM), .MemToReg_EX_MEM(MemToReg_EX_MEM), .mfc0_EX_MEM(mfc0_EX_MEM),
        .MemWrite_EX_MEM(MemWrite_EX_MEM), .RegWrite_EX_MEM(RegWrite_EX_MEM),
        .LB_EX_MEM(LB_EX_MEM), .LBU_EX_MEM(LBU_EX_MEM), .LH_EX_MEM(LH_EX_MEM), .LHU_EX_MEM(LHU_EX_MEM),
        .LW_EX_MEM(LW_EX_MEM), .MULT_EX_MEM(MULT_EX_MEM), .MFHL_EX_MEM(MFHL_EX_MEM), .MTHL_EX_MEM(MTHL_EX_MEM),
        .RegWaddr_EX_MEM(RegWaddr_EX_MEM), .ALUResult_EX_MEM(ALUResult_EX_MEM), .MemWdata_EX_MEM(MemWdata_EX_MEM),
        .PC_EX_MEM(PC_EX_MEM), .RegRdata1_EX_MEM(RegRdata1_EX_MEM), .RegRdata2_EX_MEM(RegRdata2_EX_MEM),
        .cp0Rdata_EX_MEM(cp0Rdata_EX_MEM), .s_size_EX_MEM(s_size_EX_MEM),
        .muldiv_hi(muldiv_hi), .muldiv_lo(muldiv_lo),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .wb_allowin(wb_allowin),
        .mem_to_wb_valid(mem_to_wb_valid), .RegWrite_MEM_WB(RegWrite_MEM_WB), .RegWaddr_MEM_WB(RegWaddr_MEM_WB),
        .RegWdata_MEM_WB(RegWdata_MEM_WB), .PC_MEM_WB(PC_MEM_WB), .Bypass_MEM(Bypass_MEM),
`ifdef MEM_STALL_CNT_EN
        .mem_stall_cnt(mem_stall_cnt),
`endif
        .mem_fwd_valid(mem_fwd_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && data_req && data_addr_ok) hs_cnt++;
        if (!rst && mem_to_wb_valid && wb_allowin) commit_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ex();
        exe_to_mem_valid = 0; MemEn_EX_MEM = 0; MemToReg_EX_MEM = 0; mfc0_EX_MEM = 0;
        MemWrite_EX_MEM = 0; RegWrite_EX_MEM = 0; LB_EX_MEM = 0; LBU_EX_MEM = 0; LH_EX_MEM = 0; LHU_EX_MEM = 0;
        LW_EX_MEM = 0; MULT_EX_MEM = 0; MFHL_EX_MEM = 0; MTHL_EX_MEM = 0; RegWaddr_EX_MEM = 0;
        ALUResult_EX_MEM = 0; MemWdata_EX_MEM = 0; PC_EX_MEM = 0; RegRdata1_EX_MEM = 0; RegRdata2_EX_MEM = 0;
        cp0Rdata_EX_MEM = 0; s_size_EX_MEM = 0;
    endtask

    // One load with immediate SRAM responses; ends right after the commit edge.
    task automatic do_load(input logic [31:0] addr, input logic [31:0] rd, input logic [31:0] r2,
                           input logic [3:0] bh, input logic [1:0] lw);
        clear_ex();
        exe_to_mem_valid = 1; MemEn_EX_MEM = 1; MemToReg_EX_MEM = 1; RegWrite_EX_MEM = 4'hF;
        RegWaddr_EX_MEM = 5'd3; ALUResult_EX_MEM = addr; RegRdata2_EX_MEM = r2;
        {LB_EX_MEM, LBU_EX_MEM, LH_EX_MEM, LHU_EX_MEM} = bh; LW_EX_MEM = lw;
        tick(); exe_to_mem_valid = 0; data_addr_ok = 1;
        tick(); data_addr_ok = 0; data_data_ok = 1; data_rdata = rd;
        tick(); data_data_ok = 0;
        tick();
    endtask

    task automatic do_alu(input logic [1:0] mult, input logic [1:0] mfhl, input logic [1:0] mthl, input logic [31:0] r1);
        clear_ex();
        exe_to_mem_valid = 1; MULT_EX_MEM = mult; MFHL_EX_MEM = mfhl; MTHL_EX_MEM = mthl;
        RegRdata1_EX_MEM = r1; RegWrite_EX_MEM = (mfhl != 0) ? 4'hF : 4'h0; RegWaddr_EX_MEM = 5'd8;
        tick(); exe_to_mem_valid = 0;
    endtask

    initial begin
        clear_ex();
        muldiv_hi = 0; muldiv_lo = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0; wb_allowin = 1;
        tick(); tick();
        chk("rst_allowin", mem_allowin, 1);
        chk("rst_req", data_req, 0);
        chk("rst_wbvalid", mem_to_wb_valid, 0);
        chk("rst_regwrite", RegWrite_MEM_WB, 0);
        chk("rst_bypass", Bypass_MEM, 0);
        rst = 0;
        tick();

        // LW 0x100: addr_ok in cycle 1, data_ok in cycle 3
        exe_to_mem_valid = 1; MemEn_EX_MEM = 1; MemToReg_EX_MEM = 1; LW_EX_MEM = 2'b11;
        RegWrite_EX_MEM = 4'hF; RegWaddr_EX_MEM = 5'd5; ALUResult_EX_MEM = 32'h100; PC_EX_MEM = 32'h1000;
        tick(); exe_to_mem_valid = 0;
        chk("lw_allowin_c0", mem_allowin, 0);
        chk("lw_req", data_req, 1);
        chk("lw_addr", data_addr, 32'h100);
        chk("lw_wr", data_wr, 0);
        chk("lw_size", data_size, 2);
        data_addr_ok = 1;
        tick(); data_addr_ok = 0;
        chk("lw_req_drop", data_req, 0);
        chk("lw_allowin_c2", mem_allowin, 0);
        tick(); data_data_ok = 1; data_rdata = 32'h12345678;
        #1 chk("lw_allowin_c3", mem_allowin, 0);
        tick(); data_data_ok = 0;
        chk("lw_wbvalid", mem_to_wb_valid, 1);
        chk("lw_bypass", Bypass_MEM, 32'h12345678);
        chk("lw_fwd", mem_fwd_valid, 1);
        chk("lw_allowin_done", mem_allowin, 1);
        tick();
        chk("lw_wdata", RegWdata_MEM_WB, 32'h12345678);
        chk("lw_wen", RegWrite_MEM_WB, 4'hF);
        chk("lw_waddr", RegWaddr_MEM_WB, 5);
        chk("lw_pc", PC_MEM_WB, 32'h1000);
        tick();
        chk("idle_wen_zero", RegWrite_MEM_WB, 0);

        do_load(32'h103, 32'h80FF0011, 0, 4'b1000, 2'b00); chk("lb_k3", RegWdata_MEM_WB, 32'hFFFFFF80);
        do_load(32'h103, 32'h80FF0011, 0, 4'b0100, 2'b00); chk("lbu_k3", RegWdata_MEM_WB, 32'h00000080);
        do_load(32'h102, 32'h80FF0011, 0, 4'b0010, 2'b00); chk("lh_k2", RegWdata_MEM_WB, 32'hFFFF80FF);
        do_load(32'h102, 32'h80FF0011, 0, 4'b0001, 2'b00); chk("lhu_k2", RegWdata_MEM_WB, 32'h000080FF);
        do_load(32'h101, 32'hAABBCCDD, 32'h11223344, 4'b0000, 2'b01); chk("lwl_k1", RegWdata_MEM_WB, 32'hCCDD3344);
        do_load(32'h101, 32'hAABBCCDD, 32'h11223344, 4'b0000, 2'b10); chk("lwr_k1", RegWdata_MEM_WB, 32'h11AABBCC);

        // MULT then MFHI back-to-back, then MFLO
        muldiv_hi = 32'h1; muldiv_lo = 32'h2;
        clear_ex(); exe_to_mem_valid = 1; MULT_EX_MEM = 2'b11;
        tick();
        MULT_EX_MEM = 2'b00; MFHL_EX_MEM = 2'b10; RegWrite_EX_MEM = 4'hF; RegWaddr_EX_MEM = 5'd8;
        tick(); exe_to_mem_valid = 0;
        chk("mfhi_bypass", Bypass_MEM, 32'h1);
        chk("mfhi_fwd", mem_fwd_valid, 1);
        tick();
        chk("mfhi_wdata", RegWdata_MEM_WB, 32'h1);
        chk("mfhi_waddr", RegWaddr_MEM_WB, 8);
        do_alu(2'b00, 2'b01, 2'b00, 0); tick(); chk("mflo_wdata", RegWdata_MEM_WB, 32'h2);
        do_alu(2'b00, 2'b00, 2'b10, 32'hDEADBEEF); tick();
        do_alu(2'b00, 2'b10, 2'b00, 0); tick(); chk("mthi_mfhi", RegWdata_MEM_WB, 32'hDEADBEEF);

        // SW held by WB for 4 cycles; stray data_ok in REQ must be ignored
        clear_ex(); wb_allowin = 0; hs0 = hs_cnt; cm0 = commit_cnt;
        exe_to_mem_valid = 1; MemEn_EX_MEM = 1; MemWrite_EX_MEM = 4'hF; s_size_EX_MEM = 3'd2;
        ALUResult_EX_MEM = 32'h200; MemWdata_EX_MEM = 32'hCAFEF00D; PC_EX_MEM = 32'h2000;
        tick(); exe_to_mem_valid = 0;
        chk("sw_wr", data_wr, 1);
        chk("sw_wstrb", data_wstrb, 4'hF);
        chk("sw_wdata", data_wdata, 32'hCAFEF00D);
        data_data_ok = 1;
        tick(); data_data_ok = 0;
        chk("sw_req_hold", data_req, 1);
        chk("sw_addr_hold", data_addr, 32'h200);
        data_addr_ok = 1;
        tick(); data_addr_ok = 0; data_data_ok = 1;
        tick(); data_data_ok = 0;
        for (int i = 0; i < 4; i++) begin
            chk("sw_stall_valid", mem_to_wb_valid, 1);
            chk("sw_stall_allowin", mem_allowin, 0);
            chk("sw_stall_pc_hold", PC_MEM_WB, 32'h0);
            tick();
        end
        wb_allowin = 1;
        tick();
        chk("sw_pc", PC_MEM_WB, 32'h2000);
        chk("sw_wen", RegWrite_MEM_WB, 0);
        chk("sw_handshakes", hs_cnt - hs0, 1);
        chk("sw_commits", commit_cnt - cm0, 1);

        // reset while waiting for read data
        clear_ex(); exe_to_mem_valid = 1; MemEn_EX_MEM = 1; MemToReg_EX_MEM = 1; LW_EX_MEM = 2'b11;
        RegWrite_EX_MEM = 4'hF; ALUResult_EX_MEM = 32'h300;
        tick(); exe_to_mem_valid = 0; data_addr_ok = 1;
        tick(); data_addr_ok = 0;
        rst = 1;
        #1 chk("arst_req", data_req, 0);
        chk("arst_allowin", mem_allowin, 1);
        chk("arst_wdata", RegWdata_MEM_WB, 0);
        tick(); rst = 0; data_data_ok = 1; data_rdata = 32'h55;
        tick(); data_data_ok = 0;
        chk("late_ok_wbvalid", mem_to_wb_valid, 0);
        chk("late_ok_req", data_req, 0);
        do_alu(2'b00, 2'b10, 2'b00, 0);
        chk("hi_reset_bypass", Bypass_MEM, 0);
        tick(); chk("hi_reset", RegWdata_MEM_WB, 0);
        do_alu(2'b00, 2'b01, 2'b00, 0); tick(); chk("lo_reset", RegWdata_MEM_WB, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage; upstream of writeback.
- Latches EX→MEM control/data on the valid/allowin handshake and issues the data-SRAM request (req/addr_ok/data_ok).
- Aligns load data (LB/LBU/LH/LHU/LW/LWL/LWR), owns the HI/LO registers (MULT/DIV, MTHI/MTLO, MFHI/MFLO) and produces the writeback value plus the MEM forwarding bus.

Parameters:
HI_RESET, 32'd0, reset value of HI
LO_RESET, 32'd0, reset value of LO

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
exe_to_mem_valid  in  1  EX holds a valid instruction
mem_allowin  out  1  MEM can accept this cycle
MemEn_EX_MEM, MemToReg_EX_MEM, mfc0_EX_MEM  in  1 each  control from EX
MemWrite_EX_MEM, RegWrite_EX_MEM  in  4 each  byte-enable masks
LB/LBU/LH/LHU_EX_MEM  in  1 each  load type
LW_EX_MEM  in  2  11=LW, 01=LWL, 10=LWR
MULT_EX_MEM, MFHL_EX_MEM, MTHL_EX_MEM  in  2 each  bit1=HI, bit0=LO
RegWaddr_EX_MEM  in  5  destination register
ALUResult_EX_MEM, MemWdata_EX_MEM, PC_EX_MEM, RegRdata1_EX_MEM, RegRdata2_EX_MEM, cp0Rdata_EX_MEM  in  32 each
s_size_EX_MEM  in  3  store size, [1:0] = SRAM size code
muldiv_hi, muldiv_lo  in  32 each  multiplier/divider result
data_req  out  1; data_wr  out  1; data_size  out  2; data_addr  out  32; data_wdata  out  32; data_wstrb  out  4
data_addr_ok, data_data_ok  in  1 each; data_rdata  in  32
wb_allowin  in  1
mem_to_wb_valid  out  1
RegWrite_MEM_WB  out  4; RegWaddr_MEM_WB  out  5; RegWdata_MEM_WB  out  32; PC_MEM_WB  out  32
Bypass_MEM  out  32  forwarding value
mem_fwd_valid  out  1  Bypass_MEM is final

Behaviour:
- Reset (async): mem_valid=0, state=IDLE, HI=HI_RESET, LO=LO_RESET; all captured registers, data_req and every *_MEM_WB output are 0.
- Capture on exe_to_mem_valid && mem_allowin: all inputs are latched and mem_valid<=1. Otherwise, if mem_allowin, mem_valid<=0.
- mem_allowin = !mem_valid || (mem_ready_go && wb_allowin); mem_to_wb_valid = mem_valid && mem_ready_go.
- FSM:
  - IDLE: on capture with MemEn=1 → REQ.
  - REQ: data_req=1. On data_addr_ok → WAIT.
  - WAIT: on data_data_ok, latch data_rdata → DONE.
  - DONE: on wb_allowin → IDLE, or → REQ if a new MemEn=1 instruction is captured the same cycle.
- mem_ready_go = !MemEn || state==DONE.
- A data_data_ok arriving in IDLE or REQ is ignored.
- Request fields: data_wr = |MemWrite; data_addr = ALUResult; data_wstrb = MemWrite; data_wdata = MemWdata.
  - data_size: stores use s_size[1:0]; loads use 0 for byte, 1 for half, 2 for word/LWL/LWR.
- Data fields are stable while data_req=1.
- Load align, k = ALUResult[1:0]:
  - LB/LBU: byte k, sign-/zero-extended.
  - LH/LHU: half at k[1], sign-/zero-extended.
  - LW: word unchanged.
  - LWL: (rdata << 8*(3-k)) | (Rdata2 & (32'hFFFFFFFF >> 8*(k+1))).
  - LWR: (rdata >> 8*k) | (Rdata2 & ~(32'hFFFFFFFF >> 8*k)).
- RegWdata priority: MemToReg → aligned load; mfc0 → cp0Rdata; MFHL[1] → HI; MFHL[0] → LO; else ALUResult.
- HI/LO write on commit only (mem_to_wb_valid && wb_allowin), exactly once per instruction:
  - MULT[1] → HI=muldiv_hi; MULT[0] → LO=muldiv_lo.
  - MTHL[1] → HI=Rdata1; MTHL[0] → LO=Rdata1.
  - MULT and MTHL are never both set.
- An MFHI/MFLO reading in the same cycle as an older commit sees the updated value (HI/LO bypass).
- *_MEM_WB outputs are registered on commit. When mem_to_wb_valid && !wb_allowin they hold, and RegWrite_MEM_WB is 0 when no instruction commits.
- Bypass_MEM = RegWdata (combinational) when mem_valid, else 0. mem_fwd_valid = mem_valid && |RegWrite && mem_ready_go.
- Reset mid-transaction: the FSM returns to IDLE immediately, data_req drops and the outstanding response is discarded.

Optional Feature:
- Macro MEM_STALL_CNT_EN.
- Defined: adds output mem_stall_cnt[31:0], reset to 0. It increments every cycle mem_valid && !mem_ready_go and wraps at 2^32.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- LW at addr 0x100, data_addr_ok at cycle 1, data_data_ok with 0x12345678 at cycle 3 → RegWdata_MEM_WB=0x12345678; mem_allowin=0 from capture until commit.
- LB at k=3 with rdata 0x80FF0011 → 0xFFFFFF80; LBU → 0x00000080; LH at k=2 → 0xFFFF80FF.
- LWL at k=1, rdata 0xAABBCCDD, Rdata2 0x11223344 → 0xCCDD3344; LWR at k=1 → 0x11AABBCC.
- MULT writes HI=0x1/LO=0x2; the following MFHI commits 0x00000001 back-to-back.
- SW with wb_allowin=0 for 4 cycles → one data_req handshake, outputs held, a single commit after release.
- rst asserted while in WAIT; a later data_data_ok → ignored, state IDLE, HI/LO at their reset values.
